// File: rtl/softmax_norm.sv
// Softmax normalisation: buffers a row of exponentials, obtains 1/sum from the reciprocal unit, streams x*(1/sum).
// Optional build macro SOFTMAX_NORM_ROUND_EN: round half up on the normalising product instead of flooring.
module softmax_norm #(
  parameter int WIDTH   = 32,
  parameter int Q       = 26,
  parameter int MAX_LEN = 64,
  parameter int ACC_W   = WIDTH + $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             recip_start,
  output logic [WIDTH-1:0] recip_a_q,
  input  logic             recip_busy,
  input  logic             recip_done,
  input  logic [WIDTH-1:0] recip_y_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             len_err
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int PW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {LOAD = 2'd0, KICK = 2'd1, WAIT = 2'd2, EMIT = 2'd3} state_t;

  function automatic logic [WIDTH-1:0] sat_acc(input logic [ACC_W-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[ACC_W-1:WIDTH-1] == {(ACC_W-WIDTH+1){v[ACC_W-1]}}) r = v[WIDTH-1:0];
    else if (v[ACC_W-1]) r = {1'b1, {(WIDTH-1){1'b0}}};
    else r = {1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] sat_prod(input logic [PW-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[PW-1:WIDTH-1] == {(PW-WIDTH+1){v[PW-1]}}) r = v[WIDTH-1:0];
    else if (v[PW-1]) r = {1'b1, {(WIDTH-1){1'b0}}};
    else r = {1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction

  state_t                    state_r, state_next_s;
  logic [WIDTH-1:0]          row_mem [MAX_LEN];
  logic [CW-1:0]             count_r, count_next_s, ptr_r;
  logic signed [ACC_W-1:0]   acc_r, acc_sum_s;
  logic [WIDTH-1:0]          recip_reg_r, rd_s, norm_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [PW-1:0]      prod_ext_s, rnd_s, shifted_s;
  logic accept_s, at_cap_s, row_end_s, sum_le0_s, kick_fire_s, emit_done_s, emit_load_s;
  logic in_ready_r, recip_start_r, out_valid_r, out_last_r, busy_r, len_err_r;
  logic [WIDTH-1:0] recip_a_r, out_data_r;

  assign acc_sum_s   = acc_r + {{(ACC_W-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign accept_s    = (state_r == LOAD) && in_valid && in_ready_r;
  assign at_cap_s    = (count_r == CW'(MAX_LEN - 1));
  assign row_end_s   = accept_s && (in_last || at_cap_s);
  assign sum_le0_s   = acc_sum_s[ACC_W-1] || (acc_sum_s == '0);
  assign kick_fire_s = (state_r == KICK) && !recip_busy;
  assign emit_done_s = (state_r == EMIT) && out_valid_r && out_ready && out_last_r;
  assign emit_load_s = (state_r == EMIT) && !emit_done_s && (!out_valid_r || out_ready)
                       && (ptr_r != count_r);

  // Normalising multiply of the buffered element at the read pointer.
  assign rd_s       = row_mem[ptr_r[AW-1:0]];
  assign prod_s     = $signed(rd_s) * $signed(recip_reg_r);
  assign prod_ext_s = {prod_s[2*WIDTH-1], prod_s};
`ifdef SOFTMAX_NORM_ROUND_EN
  assign rnd_s      = prod_ext_s + (PW'(1) << (Q - 1));
`else
  assign rnd_s      = prod_ext_s;
`endif
  assign shifted_s  = rnd_s >>> Q;
  assign norm_s     = sat_prod(shifted_s);

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LOAD: begin
        if (row_end_s) state_next_s = sum_le0_s ? EMIT : KICK;
        else state_next_s = LOAD;
      end
      KICK: begin
        if (kick_fire_s) state_next_s = WAIT;
        else state_next_s = KICK;
      end
      WAIT: begin
        if (recip_done) state_next_s = EMIT;
        else state_next_s = WAIT;
      end
      EMIT: begin
        if (emit_done_s) state_next_s = LOAD;
        else state_next_s = EMIT;
      end
      default: state_next_s = LOAD;
    endcase
  end

  // Element count for the row, shared by busy and the buffer.
  always_comb begin
    count_next_s = count_r;
    if (emit_done_s) count_next_s = '0;
    else if (accept_s) count_next_s = count_r + CW'(1);
    else count_next_s = count_r;
  end

  // Row buffer; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept_s) row_mem[count_r[AW-1:0]] <= in_data;
  end

  // State, accumulation, reciprocal handshake and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= LOAD;
      count_r       <= '0;
      acc_r         <= '0;
      ptr_r         <= '0;
      recip_reg_r   <= '0;
      recip_a_r     <= '0;
      recip_start_r <= 1'b0;
      in_ready_r    <= 1'b0;
      busy_r        <= 1'b0;
      len_err_r     <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      out_last_r    <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      count_r       <= count_next_s;
      in_ready_r    <= (state_next_s == LOAD);
      busy_r        <= (state_next_s != LOAD) || (count_next_s != '0);
      recip_start_r <= kick_fire_s;
      len_err_r     <= row_end_s && at_cap_s && !in_last;
      if (emit_done_s) acc_r <= '0;
      else if (accept_s) acc_r <= acc_sum_s;
      if (row_end_s && !sum_le0_s) recip_a_r <= sat_acc(acc_sum_s);
      // A non-positive sum skips the reciprocal unit and normalises to zero.
      if (row_end_s && sum_le0_s) recip_reg_r <= '0;
      else if ((state_r == WAIT) && recip_done) recip_reg_r <= recip_y_q;
      if (emit_done_s) begin
        ptr_r       <= '0;
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else if (emit_load_s) begin
        ptr_r       <= ptr_r + CW'(1);
        out_valid_r <= 1'b1;
        out_data_r  <= norm_s;
        out_last_r  <= (ptr_r == count_r - CW'(1));
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign recip_start = recip_start_r;
  assign recip_a_q   = recip_a_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_last    = out_last_r;
  assign busy        = busy_r;
  assign len_err     = len_err_r;
endmodule

// File: tb/tb_softmax_norm.sv
// Self-checking bench for softmax_norm with a behavioural reciprocal unit and an output scoreboard.
module tb_softmax_norm;
  localparam int WIDTH = 32;
  localparam int Q     = 26;
  localparam int LAT   = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [WIDTH-1:0] in_data = '0, recip_y_q = '0;
  logic recip_busy = 1'b0, recip_done = 1'b0;
  logic in_ready, recip_start, out_valid, out_last, busy, len_err;
  logic [WIDTH-1:0] recip_a_q, out_data;

  softmax_norm dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .recip_start(recip_start), .recip_a_q(recip_a_q), .recip_busy(recip_busy),
    .recip_done(recip_done), .recip_y_q(recip_y_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [WIDTH-1:0] d; logic l; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int start_cnt = 0, out_cnt = 0, len_err_cnt = 0, stall_cnt = 0, model_cnt = 0;
  logic [WIDTH-1:0] last_a = '0, model_y = 32'h0100_0000;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [WIDTH-1:0] pd = '0;

  function automatic logic [WIDTH-1:0] norm_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
`ifdef SOFTMAX_NORM_ROUND_EN
    p = p + (longint'(1) << (Q - 1));
`endif
    p = p >>> Q;
    if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (p < -64'sh8000_0000) return 32'h8000_0000;
    return p[31:0];
  endfunction

  // Reciprocal unit model: answers LAT cycles after a start with model_y; ignores rst_n.
  always @(negedge clk) begin
    recip_done = 1'b0;
    if (recip_start) start_cnt++;
    if (recip_busy) begin
      model_cnt--;
      if (model_cnt == 0) begin
        recip_done = 1'b1;
        recip_y_q  = model_y;
        recip_busy = 1'b0;
      end
    end else if (recip_start) begin
      last_a     = recip_a_q;
      recip_busy = 1'b1;
      model_cnt  = LAT;
    end
  end

  // Output monitor: stall stability and scoreboard comparison.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (pv && !pr) begin
        total++; stall_cnt++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          bad++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", out_valid, out_data, out_last, pd, pl);
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got d=%h l=%b want no output", out_data, out_last);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            bad++;
            $display("FAIL sb_out: got d=%h l=%b want d=%h l=%b", out_data, out_last, e.d, e.l);
          end
        end
      end
      if (len_err === 1'b1) len_err_cnt++;
    end
    pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
  end

  task automatic push_row(input logic [WIDTH-1:0] vals[$]);
    longint sum = 0;
    logic [WIDTH-1:0] y;
    foreach (vals[i]) sum += longint'($signed(vals[i]));
    y = (sum <= 0) ? 32'h0 : model_y;
    foreach (vals[i]) sb.push_back('{d: norm_model(vals[i], y), l: (i == vals.size() - 1)});
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic l);
    int g = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && g < 500) begin @(negedge clk); g++; end
    if (g >= 500) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: got in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_row(input logic [WIDTH-1:0] vals[$]);
    push_row(vals);
    foreach (vals[i]) drive(vals[i], i == vals.size() - 1);
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((sb.size() != 0 || recip_busy) && g < 3000) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_drain: got pending=%0d busy=%b in_ready=%b want 0 0 1", name, sb.size(), busy, in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({in_ready, recip_start, recip_a_q, out_valid, out_data, out_last, busy, len_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b st=%b a=%h v=%b d=%h l=%b busy=%b le=%b want all 0",
               in_ready, recip_start, recip_a_q, out_valid, out_data, out_last, busy, len_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_uniform();
    int s0 = start_cnt;
    send_row('{32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000});
    wait_drain("uniform");
    total++;
    if (start_cnt - s0 != 1 || last_a !== 32'h1000_0000) begin
      bad++;
      $display("FAIL uniform_recip: got starts=%0d a=%h want 1 10000000", start_cnt - s0, last_a);
    end
  endtask

  task automatic test_ratio();
    send_row('{32'h0400_0000, 32'h0C00_0000});
    wait_drain("ratio");
    send_row('{32'h0800_0000, 32'hFC00_0000});
    wait_drain("negative");
  endtask

  task automatic test_round();
    model_y = 32'h0200_0000;
    send_row('{32'h0400_0001, 32'h0000_0003, 32'h0000_0005});
    wait_drain("round");
    model_y = 32'h0100_0000;
  endtask

  task automatic test_zero();
    int s0 = start_cnt;
    send_row('{32'h0000_0000});
    wait_drain("zero");
    send_row('{32'hF800_0000});
    wait_drain("negsum");
    total++;
    if (start_cnt != s0) begin
      bad++;
      $display("FAIL zero_no_start: got starts=%0d want 0", start_cnt - s0);
    end
  endtask

  task automatic test_sat();
    logic [WIDTH-1:0] v[$];
    for (int i = 0; i < 64; i++) v.push_back(32'h7C00_0000);
    send_row(v);
    wait_drain("sat");
    total++;
    if (last_a !== 32'h7FFF_FFFF) begin
      bad++;
      $display("FAIL sat_recip_a: got %h want 7fffffff", last_a);
    end
  endtask

  task automatic test_trunc();
    logic [WIDTH-1:0] r1[$], r2[$];
    int le0 = len_err_cnt;
    for (int i = 0; i < 64; i++) r1.push_back(32'h0100_0000);
    for (int i = 0; i < 7; i++) r2.push_back(32'h0100_0000 + WIDTH'(i));
    push_row(r1);
    push_row(r2);
    foreach (r1[i]) drive(r1[i], 1'b0);
    for (int i = 0; i < 6; i++) drive(r2[i], 1'b0);
    drive(r2[6], 1'b1);
    wait_drain("trunc");
    total++;
    if (len_err_cnt - le0 != 1) begin
      bad++;
      $display("FAIL trunc_len_err: got pulses=%0d want 1", len_err_cnt - le0);
    end
  endtask

  task automatic test_stall();
    int g = 0, k = 0, s0 = stall_cnt;
    logic [3:0] pat = 4'b1001;
    send_row('{32'h0400_0000, 32'h0800_0000, 32'h0C00_0000, 32'h1000_0000, 32'h0200_0000});
    while (sb.size() != 0 && g < 500) begin
      if (out_valid) begin out_ready = pat[3 - (k % 4)]; k++; end
      @(negedge clk); g++;
    end
    out_ready = 1'b1;
    wait_drain("stall");
    total++;
    if (stall_cnt == s0) begin
      bad++;
      $display("FAIL stall_seen: got stalls=%0d want >0", stall_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    send_row('{32'h0200_0000, 32'h0600_0000});
    send_row('{32'h0800_0000});
    wait_drain("b2b");
  endtask

  task automatic test_reset_wait();
    int g = 0, s0 = start_cnt, o0;
    send_row('{32'h0400_0000, 32'h0400_0000});
    while (start_cnt == s0 && g < 100) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, recip_start, recip_a_q, out_valid, out_data, out_last, busy, len_err} !== '0) begin
      bad++;
      $display("FAIL rst_wait_outputs: got rdy=%b a=%h v=%b busy=%b want all 0", in_ready, recip_a_q, out_valid, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    o0 = out_cnt;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait_ready: got in_ready=%b want 1", in_ready);
    end
    repeat (20) @(negedge clk);
    total++;
    if (out_cnt != o0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait_late_done: got outputs=%0d want 0", out_cnt - o0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_uniform();
    test_ratio();
    test_round();
    test_zero();
    test_sat();
    test_trunc();
    test_stall();
    test_back_to_back();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
